crossing_request_unit: RTL and testbench

- Pedestrian-side front end for the crosswalk control unit.
- Conditions two raw push-button inputs and turns each into a held request level on `p` and `q`, which feed the control unit.
- Watches the control unit's `ts` output and withdraws each request once the walk phase is served.
- Drives per-side "request registered" wait lamps.

---
 rtl/crossing_request_unit_pkg.sv | 18 +
 rtl/crossing_request_unit_if.sv | 13 +
 rtl/crossing_request_unit_channel.sv | 84 ++++++++
 rtl/crossing_request_unit.sv | 43 ++++
 tb/tb_crossing_request_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crossing_request_unit_pkg.sv
// Shared types and constants for the crossing request unit: channel states and ts encodings.
package cru_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RELEASE = 2'd2
   } cru_state_t;

   localparam logic [1:0] TS_CAR_GREEN  = 2'b00;
   localparam logic [1:0] TS_CAR_YELLOW = 2'b01;
   localparam logic [1:0] TS_WALK       = 2'b10;
   localparam logic [1:0] TS_CLEAR      = 2'b11;

   localparam int DEB_CNT_W = 6;
   typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

endpackage

// File: rtl/crossing_request_unit_if.sv
// Pedestrian-side bus: raw buttons and ts in, held requests and wait lamps out.
interface crossing_request_unit_if;
   logic       btn_p;
   logic       btn_q;
   logic [1:0] ts;
   logic       p;
   logic       q;
   logic       wait_p;
   logic       wait_q;

   modport master (output btn_p, btn_q, ts, input p, q, wait_p, wait_q);
   modport slave  (input btn_p, btn_q, ts, output p, q, wait_p, wait_q);
endinterface

// File: rtl/crossing_request_unit_channel.sv
// One pedestrian channel: 2-flop synchronizer, optional debounce (CRU_DEBOUNCE_EN) and request FSM.
module cru_channel
   import cru_pkg::*;
#(
   parameter deb_cnt_t DEB_CYCLES = 6'd4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic served,
   output logic req
);

   logic       sync1;
   logic       sync2;
   logic       acc;
   logic       acc_prev;
   logic       rise;
   cru_state_t state;
   cru_state_t next_state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef CRU_DEBOUNCE_EN
   deb_cnt_t deb_cnt;
   logic     acc_reg;

   // The counter measures how long the synchronized level has disagreed with the accepted one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_cnt <= '0;
         acc_reg <= 1'b0;
      end else if (sync2 == acc_reg) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_CYCLES - deb_cnt_t'(1)) begin
         acc_reg <= sync2;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + deb_cnt_t'(1);
      end
   end

   assign acc = acc_reg;
`else
   assign acc = sync2;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_prev <= 1'b0;
         state    <= IDLE;
      end else begin
         acc_prev <= acc;
         state    <= next_state;
      end
   end

   assign rise = acc & ~acc_prev;

   // A press that lands while walk is already showing is absorbed straight into RELEASE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (rise)   next_state = served ? RELEASE : ARMED;
         ARMED:   if (served) next_state = RELEASE;
         RELEASE: if (!acc)   next_state = IDLE;
         default:             next_state = IDLE;
      endcase
   end

   always_comb begin
      req = 1'b0;
      if (state == ARMED) req = 1'b1;
   end

endmodule

// File: rtl/crossing_request_unit.sv
// Crosswalk pedestrian front end: two request channels sharing one registered ts.
// Debounce counters are present only when CRU_DEBOUNCE_EN is defined.
module crossing_request_unit
   import cru_pkg::*;
#(
   parameter deb_cnt_t   DEB_CYCLES = 6'd4,
   parameter logic [1:0] TS_WALK    = cru_pkg::TS_WALK
) (
   input logic clk,
   input logic reset,
   crossing_request_unit_if.slave bus
);

   logic [1:0] ts_r;
   logic       served;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ts_r <= TS_CAR_GREEN;
      else        ts_r <= bus.ts;
   end

   assign served = (ts_r == TS_WALK);

   cru_channel #(.DEB_CYCLES(DEB_CYCLES)) cru_channel_p (
      .clk    (clk),
      .reset  (reset),
      .btn    (bus.btn_p),
      .served (served),
      .req    (bus.p)
   );

   cru_channel #(.DEB_CYCLES(DEB_CYCLES)) cru_channel_q (
      .clk    (clk),
      .reset  (reset),
      .btn    (bus.btn_q),
      .served (served),
      .req    (bus.q)
   );

   assign bus.wait_p = bus.p;
   assign bus.wait_q = bus.q;

endmodule

// File: tb/tb_crossing_request_unit.sv
// Bench for crossing_request_unit: directed steps plus random buttons/ts against a cycle model.
module tb_crossing_request_unit;
   import cru_pkg::*;

   localparam logic [5:0] DEB = 6'd4;
`ifdef CRU_DEBOUNCE_EN
   localparam int LAT = 2 + int'(DEB) + 1;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   crossing_request_unit_if bus ();

   crossing_request_unit #(.DEB_CYCLES(DEB), .TS_WALK(TS_WALK)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   // Reference model: button sample history, accepted level, request and "wait for release" flags.
   bit       btn_hist [2][$];
   bit       acc_seen [2];
   bit       req_m    [2];
   bit       hold_m   [2];
   bit [1:0] tsr_m;
`ifdef CRU_DEBOUNCE_EN
   bit       acc_m    [2];
   bit       win      [2][$];
`endif

   function automatic void model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         btn_hist[ch] = '{1'b0, 1'b0};
         acc_seen[ch] = 1'b0;
         req_m[ch]    = 1'b0;
         hold_m[ch]   = 1'b0;
`ifdef CRU_DEBOUNCE_EN
         acc_m[ch] = 1'b0;
         win[ch].delete();
`endif
      end
      tsr_m = 2'b00;
   endfunction

   // One rising edge: a level is accepted once DEB successive synchronized samples disagree with it.
   function automatic void model_edge();
      bit b, sync, acc_used, served, rise;
      served = (tsr_m == TS_WALK);
      for (int ch = 0; ch < 2; ch++) begin
         b    = (ch == 0) ? bus.btn_p : bus.btn_q;
         sync = btn_hist[ch][0];
`ifdef CRU_DEBOUNCE_EN
         acc_used = acc_m[ch];
`else
         acc_used = sync;
`endif
         rise = acc_used && !acc_seen[ch];
         if (req_m[ch]) begin
            if (served) begin
               req_m[ch]  = 1'b0;
               hold_m[ch] = 1'b1;
            end
         end else if (hold_m[ch]) begin
            if (!acc_used) hold_m[ch] = 1'b0;
         end else if (rise) begin
            if (served) hold_m[ch] = 1'b1;
            else        req_m[ch]  = 1'b1;
         end
         acc_seen[ch] = acc_used;
`ifdef CRU_DEBOUNCE_EN
         begin
            bit differ;
            win[ch].push_back(sync);
            if (win[ch].size() > int'(DEB)) void'(win[ch].pop_front());
            if (win[ch].size() == int'(DEB)) begin
               differ = 1'b1;
               foreach (win[ch][k]) if (win[ch][k] == acc_m[ch]) differ = 1'b0;
               if (differ) acc_m[ch] = sync;
            end
         end
`endif
         btn_hist[ch].push_back(b);
         void'(btn_hist[ch].pop_front());
      end
      tsr_m = bus.ts;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0b, expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check("p",      bus.p,      req_m[0]);
      check("q",      bus.q,      req_m[1]);
      check("wait_p", bus.wait_p, req_m[0]);
      check("wait_q", bus.wait_q, req_m[1]);
   endtask

   task automatic cycle_once();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic applyStimulus(input logic bp, input logic bq, input logic [1:0] t, input int cycles);
      bus.btn_p = bp;
      bus.btn_q = bq;
      bus.ts    = t;
      repeat (cycles) cycle_once();
   endtask

   task automatic wait_p_rise(input string tag, input int exp_lat);
      int n;
      n = 0;
      do begin
         cycle_once();
         n++;
      end while (!bus.p && n < 40);
      check_int(tag, n, exp_lat);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      model_reset();
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b0, TS_CAR_GREEN, 3);
      check("reset_p", bus.p, 1'b0);
      check("reset_wait_p", bus.wait_p, 1'b0);

      rst_n = 1'b1;
      wait_p_rise("lat_after_reset", LAT);

      applyStimulus(1'b1, 1'b0, TS_CAR_YELLOW, 50);
      applyStimulus(1'b1, 1'b0, TS_CAR_GREEN, 50);
      applyStimulus(1'b1, 1'b0, TS_CLEAR, 50);
      check("hold_non_walk", bus.p, 1'b1);

      applyStimulus(1'b1, 1'b0, TS_WALK, 1);
      check("serve_1cyc_p", bus.p, 1'b1);
      applyStimulus(1'b1, 1'b0, TS_WALK, 1);
      check("serve_2cyc_p", bus.p, 1'b0);
      check("serve_2cyc_wait", bus.wait_p, 1'b0);

      applyStimulus(1'b1, 1'b0, TS_CAR_GREEN, 20);
      check("held_no_rearm", bus.p, 1'b0);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);
      bus.btn_p = 1'b1;
      wait_p_rise("lat_fresh_press", LAT);
      applyStimulus(1'b1, 1'b0, TS_WALK, 2);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);

      // Bounce: toggle every two cycles for twenty cycles, ending low.
      for (int i = 0; i < 10; i++) applyStimulus(~bus.btn_p, 1'b0, TS_CAR_GREEN, 2);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);
`ifdef CRU_DEBOUNCE_EN
      check("bounce_low_p", bus.p, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(~bus.btn_p, 1'b0, TS_CAR_GREEN, 2);
      bus.btn_p = 1'b1;
      wait_p_rise("bounce_then_hold", LAT);
`else
      for (int i = 0; i < 8; i++) applyStimulus(~bus.btn_p, 1'b0, TS_CAR_GREEN, 2);
      applyStimulus(1'b1, 1'b0, TS_CAR_GREEN, 10);
      check("bounce_then_hold", bus.p, 1'b1);
`endif
      applyStimulus(1'b1, 1'b0, TS_WALK, 2);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);

      bus.btn_p = 1'b1;
      bus.btn_q = 1'b1;
      wait_p_rise("sim_lat_p", LAT);
      check("sim_q", bus.q, 1'b1);
      applyStimulus(1'b1, 1'b1, TS_WALK, 1);
      check("sim_serve1_q", bus.q, 1'b1);
      applyStimulus(1'b1, 1'b1, TS_WALK, 1);
      check("sim_clear_p", bus.p, 1'b0);
      check("sim_clear_q", bus.q, 1'b0);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);

      applyStimulus(1'b0, 1'b0, TS_WALK, 3);
      applyStimulus(1'b1, 1'b0, TS_WALK, LAT + 3);
      check("absorb_walk_p", bus.p, 1'b0);
      applyStimulus(1'b1, 1'b0, TS_CAR_GREEN, 10);
      check("absorb_after_p", bus.p, 1'b0);
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);

      bus.btn_p = 1'b1;
      wait_p_rise("lat_before_reset", LAT);
      bus.btn_p = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_p", bus.p, 1'b0);
      check("async_reset_wait_p", bus.wait_p, 1'b0);
      @(negedge clk);
      cycle_once();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, TS_CAR_GREEN, 10);
      check("after_reset_p", bus.p, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         int r;
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            model_reset();
            cycle_once();
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) bus.btn_p = ~bus.btn_p;
         if ($urandom_range(0, 9) == 0) bus.btn_q = ~bus.btn_q;
         r = int'($urandom_range(0, 15));
         if (r < 2)       bus.ts = TS_WALK;
         else if (r == 3) bus.ts = TS_CLEAR;
         else if (r == 4) bus.ts = TS_CAR_YELLOW;
         else             bus.ts = TS_CAR_GREEN;
         cycle_once();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
